// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [6:0] OPCODE_R = 7'b0110011;
    localparam logic [6:0] FUNCT7_M = 7'h01;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // DIV and REM treat operands as signed; DIVU and REMU do not.
    function automatic logic is_signed_div(input logic [2:0] funct3);
        return funct3[2] & ~funct3[0];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Core-side request/result bundle for the multiply/divide sequencer.
interface muldiv_sequencer_if #(parameter int XLEN = 32);
    logic            req;
    logic [2:0]      funct3;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic            stall;
    logic            done;
    logic            busy;
    logic [XLEN-1:0] result;

    modport master (output req, funct3, srcA, srcB, input stall, done, busy, result);
    modport slave  (input req, funct3, srcA, srcB, output stall, done, busy, result);
endinterface

// File: rtl/muldiv_sequencer_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract if it fits.
module div_step #(parameter int XLEN = 32) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    // The top bit of the extra-wide difference is the borrow: set means the divisor did not fit.
    always_comb begin
        o_rem = w_shift[XLEN-1:0];
        o_quo = {i_quo[XLEN-2:0], 1'b0};
        if (w_diff[XLEN] == 1'b0) begin
            o_rem = w_diff[XLEN-1:0];
            o_quo = {i_quo[XLEN-2:0], 1'b1};
        end else begin
            o_rem = w_shift[XLEN-1:0];
            o_quo = {i_quo[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M sequencer: one-cycle multiply, XLEN-cycle restoring divide, stalls the core meanwhile.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                resetN,
    muldiv_sequencer_if.slave   bus
);
    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] x);
        return ~x + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic is_signed);
        return (is_signed & x[XLEN-1]) ? neg2(x) : x;
    endfunction

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_opa;
    logic [XLEN-1:0] r_opb;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_result;
    logic            r_done;
    logic            r_busy;

    logic            w_div_signed;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_a_sx;
    logic            w_b_sx;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_mul_res;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_q_fin;
    logic [XLEN-1:0] w_r_fin;
    logic [XLEN-1:0] w_div_res;

    assign w_div_signed = is_signed_div(bus.funct3);
    assign w_b_zero     = (bus.srcB == ZERO);
    assign w_ovf        = w_div_signed & (bus.srcA == MIN_NEG) & (bus.srcB == ALL_ONES);
    assign w_special    = bus.funct3[2] & (w_b_zero | w_ovf);

    // Divide-by-zero and signed overflow are answered straight from the request.
    always_comb begin
        w_special_res = ZERO;
        if (bus.funct3[1]) begin
            w_special_res = w_b_zero ? bus.srcA : ZERO;
        end else begin
            w_special_res = w_b_zero ? ALL_ONES : MIN_NEG;
        end
    end

    // Low half of a 2*XLEN product is the same for any extension, so only the high ops care.
    assign w_a_sx    = r_opa[XLEN-1] & (r_funct3 != F3_MULHU);
    assign w_b_sx    = r_opb[XLEN-1] & (r_funct3 == F3_MULH);
    assign w_prod    = {{XLEN{w_a_sx}}, r_opa} * {{XLEN{w_b_sx}}, r_opb};
    assign w_mul_res = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    div_step #(.XLEN(XLEN)) u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_opb),
        .o_rem     (w_rem),
        .o_quo     (w_quo)
    );

    assign w_q_fin   = r_neg_q ? neg2(w_quo) : w_quo;
    assign w_r_fin   = r_neg_r ? neg2(w_rem) : w_rem;
    assign w_div_res = r_funct3[1] ? w_r_fin : w_q_fin;

    assign bus.stall  = bus.req & (r_state != S_DONE);
    assign bus.done   = r_done;
    assign bus.busy   = r_busy;
    assign bus.result = r_result;

    // Sequencer FSM with its counter, operand registers and result register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= S_IDLE;
            r_count  <= {CW{1'b0}};
            r_funct3 <= 3'd0;
            r_opa    <= ZERO;
            r_opb    <= ZERO;
            r_rem    <= ZERO;
            r_quo    <= ZERO;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= ZERO;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_funct3 <= bus.funct3;
                        r_busy   <= 1'b1;
                        if (!bus.funct3[2]) begin
                            r_opa   <= bus.srcA;
                            r_opb   <= bus.srcB;
                            r_state <= S_MUL;
                        end else if (w_special) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_quo   <= mag(bus.srcA, w_div_signed);
                            r_opb   <= mag(bus.srcB, w_div_signed);
                            r_rem   <= ZERO;
                            r_count <= {CW{1'b0}};
                            r_neg_q <= w_div_signed & (bus.srcA[XLEN-1] ^ bus.srcB[XLEN-1]);
                            r_neg_r <= w_div_signed & bus.srcA[XLEN-1];
                            r_state <= S_DIV;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_result <= w_mul_res;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DIV: begin
                    r_rem <= w_rem;
                    r_quo <= w_quo;
                    if (r_count == CNT_LAST) begin
                        r_result <= w_div_res;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_count <= {CW{1'b0}};
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: directed vector table, corner sequences, and random ops vs arithmetic model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.XLEN(32)) bus();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference: wide integer math, truncating division as in RV32M.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint p = 64'sd0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 32'd0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] == 1'b0) return 2;
        if (b == 32'd0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Presents one op and waits (bounded) for done; leaves req high in the DONE cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output logic stall_ok, output logic busy_ok);
        bus.req = 1'b1;
        bus.funct3 = f3;
        bus.srcA = a;
        bus.srcB = b;
        lat = 0;
        stall_ok = 1'b1;
        busy_ok = 1'b1;
        res = 32'd0;
        #1;
        while (lat < 40) begin
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            tick();
            lat++;
            if (bus.done === 1'b1) break;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        res = bus.result;
        if (bus.stall !== 1'b0) stall_ok = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        logic        s_ok;
        logic        b_ok;
        run_op(f3, a, b, res, lat, s_ok, b_ok);
        check({name, " result"}, res, exp);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " stall"}, {31'd0, s_ok}, 32'd1);
        check({name, " busy"}, {31'd0, b_ok}, 32'd1);
        bus.req = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        s_ok;
        logic        b_ok;
        logic        saw_done;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0]  = '{"MUL 7*-3",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
        vecs[1]  = '{"MULHU max^2",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        vecs[2]  = '{"MULH min^2",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2};
        vecs[3]  = '{"MULHSU -1*max",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
        vecs[4]  = '{"DIV -7/2",        3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{"REM -7/2",        3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{"DIVU 100/7",      3'd5, 32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{"REMU 100/7",      3'd7, 32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{"DIVU 5/0",        3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{"REM 5/0",         3'd6, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{"DIV min/-1",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{"REM min/-1",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

        bus.req = 1'b0;
        bus.funct3 = 3'd0;
        bus.srcA = 32'd0;
        bus.srcB = 32'd0;
        resetN = 1'b0;
        tick();
        tick();
        check("reset result", bus.result, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset stall idle", {31'd0, bus.stall}, 32'd0);
        bus.req = 1'b1;
        #1;
        check("reset stall follows req", {31'd0, bus.stall}, 32'd1);
        bus.req = 1'b0;
        #1;
        resetN = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Back-to-back: DIVU then MUL presented in the cycle right after DONE.
        run_op(3'd5, 32'd1000, 32'd9, res, lat, s_ok, b_ok);
        check("b2b DIVU result", res, 32'd111);
        check("b2b DIVU latency", 32'(lat), 32'd33);
        check("b2b DIVU stall", {31'd0, s_ok}, 32'd1);
        tick();
        check("b2b done low after DONE", {31'd0, bus.done}, 32'd0);
        run_op(3'd0, 32'd6, 32'd7, res, lat, s_ok, b_ok);
        check("b2b MUL result", res, 32'd42);
        check("b2b MUL latency", 32'(lat), 32'd2);
        check("b2b MUL stall", {31'd0, s_ok}, 32'd1);
        bus.req = 1'b0;
        tick();

        // Reset while the divider is at count 10.
        bus.req = 1'b1;
        bus.funct3 = 3'd5;
        bus.srcA = 32'd1000;
        bus.srcB = 32'd3;
        #1;
        repeat (11) tick();
        check("mid-div busy", {31'd0, bus.busy}, 32'd1);
        resetN = 1'b0;
        bus.req = 1'b0;
        #1;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        tick();
        resetN = 1'b1;
        saw_done = 1'b0;
        repeat (35) begin
            tick();
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("no done after abort", {31'd0, saw_done}, 32'd0);
        do_op("DIVU after abort", 3'd5, 32'd1000, 32'd3, 32'd333, 33);

        // Random ops, including biased divide-by-zero and overflow operands.
        for (int n = 0; n < 150; n++) begin
            f3 = 3'($urandom_range(7, 0));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(9, 0))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(200, 0)); b = 32'($urandom_range(20, 1)); end
                3: b = 32'($urandom_range(20, 1)) ^ {32{a[0]}};
                default: ;
            endcase
            do_op("random", f3, a, b, ref_model(f3, a, b), ref_lat(f3, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
